// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory controller files.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
//   - controller state enum
//   - default depth, in 32-bit words, of the attached memory
package mem_pkg;

  localparam int DEFAULT_DEPTH = 128;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane.sv
// mem_lane: purely combinational lane logic for the memory controller.
// Build option: MEM_CTRL_RMW_EN adds the store-merge path (wdata/merged ports).
// Ports:
//   size      in  2   access size (mem_pkg encodings)
//   uns       in  1   1 = zero-extend the load, 0 = sign-extend it
//   offset    in  2   byte offset within the word (addr[1:0])
//   rdata     in  32  memory word
//   load_data out 32  selected lane, extended to 32 bits (word: rdata unchanged)
//   wdata     in  32  store data, right-aligned        (MEM_CTRL_RMW_EN only)
//   merged    out 32  rdata with the addressed lane replaced (MEM_CTRL_RMW_EN only)
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
`ifdef MEM_CTRL_RMW_EN
  input  logic [31:0] wdata,
  output logic [31:0] merged,
`endif
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    // Half lanes are picked by addr[1] alone; addr[0] is an alignment error.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~uns & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

`ifdef MEM_CTRL_RMW_EN
  always_comb begin
    merged = rdata;
    case (size)
      SZ_BYTE: merged[{offset, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = rdata;
    endcase
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding load/store controller between a core request
// port and a 32-bit word memory with combinational read data.
// Build option: define MEM_CTRL_RMW_EN to support byte/half stores through a
// read-modify-write cycle; without it such stores are answered with resp_err.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready    response handshake (valid only in RESP)
//   resp_rdata, resp_err     load result (0 for stores/errors), error flag
//   mem_addr, mem_wdata, mem_wenable, mem_rdata           word memory port
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_wenable,
  input  logic [31:0]   mem_rdata
);

  state_t        state_reg, state_next;
  logic          we_reg, uns_reg;
  logic [1:0]    size_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0]   wdata_reg, rdata_reg;
  logic          err_reg;
  logic [AW-1:0] word_idx;
  logic          access_err, sub_store;
  logic [31:0]   lane_word, lane_load;

  assign word_idx  = {2'b00, addr_reg[AW-1:2]};
  assign sub_store = we_reg && (size_reg != SZ_WORD);

  always_comb begin
    access_err = 1'b0;
    case (size_reg)
      SZ_ILL:  access_err = 1'b1;
      SZ_HALF: access_err = addr_reg[0];
      SZ_WORD: access_err = (addr_reg[1:0] != 2'b00);
      default: access_err = 1'b0;
    endcase
    if (word_idx >= AW'(DEPTH)) access_err = 1'b1;
`ifndef MEM_CTRL_RMW_EN
    if (sub_store) access_err = 1'b1;
`endif
  end

`ifdef MEM_CTRL_RMW_EN
  logic [31:0] merge_reg, lane_merged;
  // The lane unit sees live memory data in ACCESS and the saved word in RMW_WR.
  assign lane_word = (state_reg == RMW_WR) ? merge_reg : mem_rdata;
`else
  assign lane_word = mem_rdata;
`endif

  mem_lane u_lane (
    .size      (size_reg),
    .uns       (uns_reg),
    .offset    (addr_reg[1:0]),
    .rdata     (lane_word),
`ifdef MEM_CTRL_RMW_EN
    .wdata     (wdata_reg),
    .merged    (lane_merged),
`endif
    .load_data (lane_load)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (req_valid) state_next = ACCESS;
`ifdef MEM_CTRL_RMW_EN
      ACCESS: state_next = (sub_store && !access_err) ? RMW_WR : RESP;
      RMW_WR: state_next = RESP;
`else
      ACCESS: state_next = RESP;
`endif
      RESP:   if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: the memory port is idle (all zero) outside ACCESS/RMW_WR, so a
  // reset landing mid-request removes the write strobe immediately.
  always_comb begin
    req_ready   = (state_reg == IDLE);
    resp_valid  = (state_reg == RESP);
    resp_rdata  = rdata_reg;
    resp_err    = err_reg;
    mem_addr    = '0;
    mem_wdata   = 32'h0;
    mem_wenable = 1'b0;
    case (state_reg)
      ACCESS: begin
        mem_addr = word_idx;
        if (we_reg && size_reg == SZ_WORD && !access_err) begin
          mem_wenable = 1'b1;
          mem_wdata   = wdata_reg;
        end
      end
`ifdef MEM_CTRL_RMW_EN
      RMW_WR: begin
        mem_addr    = word_idx;
        mem_wenable = 1'b1;
        mem_wdata   = lane_merged;
      end
`endif
      default: ;
    endcase
  end

  // Request capture and response data; response registers only change in
  // ACCESS, which keeps them stable for the whole RESP state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= SZ_BYTE;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
`ifdef MEM_CTRL_RMW_EN
      merge_reg <= 32'h0;
`endif
    end else begin
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ACCESS) begin
        err_reg   <= access_err;
        rdata_reg <= (!we_reg && !access_err) ? lane_load : 32'h0;
`ifdef MEM_CTRL_RMW_EN
        merge_reg <= mem_rdata;
`endif
      end
    end
  end

endmodule
